// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizes and enums for the 512x8 SRAM-backed FIFO
package sram_fifo_pkg;
  localparam int WIDTH      = 8;
  localparam int DEPTH      = 512;
  localparam int ADDR_WIDTH = 9;
  localparam int CNT_WIDTH  = 10;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;
  typedef enum logic {ST_INIT, ST_RUN} st_e;
endpackage

// File: rtl/sram_fifo_outbuf.sv
// sram_fifo_outbuf: 3-entry in-order queue that absorbs RAM read returns
module sram_fifo_outbuf #(
  parameter int WIDTH = sram_fifo_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       cnt_o
);
  import sram_fifo_pkg::*;
  logic [WIDTH-1:0] e_q [3];
  logic [WIDTH-1:0] e_d [3];
  logic [1:0]       cnt_q, cnt_d, widx;
  // shift toward the head on pop, then drop the push into the first free slot
  always_comb begin
    widx   = cnt_q - 2'(pop_i);
    e_d[0] = pop_i ? e_q[1] : e_q[0];
    e_d[1] = pop_i ? e_q[2] : e_q[1];
    e_d[2] = e_q[2];
    for (int i = 0; i < 3; i++)
      if (push_i && widx == 2'(i)) e_d[i] = din_i;
    cnt_d  = cnt_q + 2'(push_i) - 2'(pop_i);
  end
  // entry and occupancy registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_q   <= '{default: '0};
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  assign dout_o = e_q[0];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/sram_fifo_512x8.sv
// sram_fifo_512x8: valid/ready byte FIFO driving a 512x8 single-port RAM; SRAM_FIFO_INIT_CLEAR_EN adds a post-reset zero sweep
module sram_fifo_512x8 #(
  parameter int WIDTH      = sram_fifo_pkg::WIDTH,
  parameter int DEPTH      = sram_fifo_pkg::DEPTH,
  parameter int ADDR_WIDTH = sram_fifo_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = sram_fifo_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  init_busy,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wd,
  input  logic [WIDTH-1:0]      ram_rd
);
  import sram_fifo_pkg::*;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  logic                  in_full_q, in_full_d;
  logic [WIDTH-1:0]      in_data_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  rd_inflight_q;
  logic [1:0]            ob_cnt;
  gnt_e                  last_q, gnt;
  logic                  wr_req, rd_req, accept, pop;
  assign wr_req = in_full_q && words_q < FULL;
  assign rd_req = words_q != '0 && ({1'b0, ob_cnt} + {2'b0, rd_inflight_q}) < 3'd3;
  // single RAM port arbiter: alternate on contention, starting with the write
  always_comb begin
    gnt       = wr_req && rd_req ? (last_q == GNT_RD ? GNT_WR : GNT_RD) :
                wr_req ? GNT_WR : rd_req ? GNT_RD : GNT_NONE;
    in_full_d = accept ? 1'b1 : gnt == GNT_WR ? 1'b0 : in_full_q;
    words_d   = words_q + (ADDR_WIDTH+1)'(gnt == GNT_WR) - (ADDR_WIDTH+1)'(gnt == GNT_RD);
    count_d   = count_q + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
  end
`ifdef SRAM_FIFO_INIT_CLEAR_EN
  st_e state_q;
  // sweep zeros through every address, reusing wr_ptr as the sweep address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_INIT;
    else if (state_q == ST_INIT && wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= ST_RUN;
  assign init_busy = rst_n && state_q == ST_INIT;
`else
  assign init_busy = 1'b0;
`endif
  assign in_ready  = rst_n && !init_busy && (!in_full_q || gnt == GNT_WR);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ram_ce    = init_busy || gnt != GNT_NONE;
  assign ram_we    = init_busy || gnt == GNT_WR;
  assign ram_addr  = ram_we ? wr_ptr_q : rd_ptr_q;
  assign ram_wd    = init_busy ? '0 : in_data_q;
  assign out_valid = ob_cnt != 2'd0;
  assign count     = count_q;
  // input register, pointers, occupancy and read-return tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_full_q     <= 1'b0;
      in_data_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      words_q       <= '0;
      count_q       <= '0;
      last_q        <= GNT_RD;
      rd_inflight_q <= 1'b0;
    end else begin
      in_full_q     <= in_full_d;
      if (accept) in_data_q <= in_data;
      if (ram_we) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (gnt == GNT_RD) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      words_q       <= words_d;
      count_q       <= count_d;
      if (gnt != GNT_NONE) last_q <= gnt;
      rd_inflight_q <= gnt == GNT_RD;
    end
  sram_fifo_outbuf #(.WIDTH(WIDTH)) u_ob (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (rd_inflight_q),
    .pop_i  (pop),
    .din_i  (ram_rd),
    .dout_o (out_data),
    .cnt_o  (ob_cnt)
  );
endmodule
